// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_pkg
//  Description : Shared types, default parameters and latency helper for the
//                successive-approximation ADC controller.
//  Revision    : 1.0  initial release
// ============================================================================
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH         = 3;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES   = 2;

  // Cycle, counted after the edge that samples start, in which done is high.
  function automatic int unsigned conv_cycles(input int unsigned width,
                                              input int unsigned settle);
    return width * (settle + 1) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_adc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_ctrl_if
//  Description : Control, comparator and result signals of the SAR ADC
//                controller. master = wrapper/bench side, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             cont;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, cont, cmp_in,
    input  dac_code, busy, done, result
  );

  modport slave (
    input  start, cont, cmp_in,
    output dac_code, busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/sar_adc_ctrl_cmp_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sync
//  Description : Multi-flop synchronizer bringing the asynchronous comparator
//                output into the clk domain. Resets to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw comparator level one stage further down the chain.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_in};
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_ctrl
//  Description : Successive-approximation controller. Drives trial codes onto
//                the resistor-ladder DAC, waits for the comparator to settle,
//                and resolves one bit per trial from MSB to LSB.
//  Revision    : 1.0  initial release
// ============================================================================
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  sar_adc_ctrl_if.slave bus
);

  localparam int K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [K_W-1:0]   K_MSB    = K_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  // Reject parameter combinations the bit loop cannot support.
  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("sar_adc_ctrl: WIDTH must be in 2..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("sar_adc_ctrl: SYNC_STAGES must be in 2..3");
  end
  if (SETTLE_CYCLES < SYNC_STAGES) begin : g_bad_settle
    $error("sar_adc_ctrl: SETTLE_CYCLES must be >= SYNC_STAGES");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cmp_sync_out;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] code_kept;

  cmp_sync #(
    .STAGES (SYNC_STAGES)
  ) u_cmp_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.cmp_in),
    .sync_out (cmp_sync_out)
  );

  // Trial code with bit k resolved: kept if the input is at or above it.
  always_comb begin
    bit_k     = WIDTH'(1) << k_q;
    code_kept = cmp_sync_out ? dac_q : (dac_q & ~bit_k);
  end

  // Next-state logic: launch, settle countdown, per-bit decision, completion.
  always_comb begin
    state_d  = state_q;
    dac_d    = dac_q;
    result_d = result_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dac_d   = MSB_CODE;
          k_d     = K_MSB;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          dac_d = result_q;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DECIDE: begin
        if (k_q != '0) begin
          // Resolve bit k and raise the next trial bit on the same edge.
          dac_d   = code_kept | (bit_k >> 1);
          k_d     = k_q - K_W'(1);
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          // Result is published on the edge that enters DONE.
          dac_d    = code_kept;
          result_d = code_kept;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.cont) begin
          dac_d   = MSB_CODE;
          k_d     = K_MSB;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dac_q    <= '0;
      result_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.dac_code = dac_q;
  assign bus.result   = result_q;
  assign bus.busy     = (state_q == SETTLE) || (state_q == DECIDE);
  assign bus.done     = (state_q == DONE);

`ifndef SYNTHESIS
  int unsigned lat_q, lat_d;
  logic        lat_launch;

  // Cycles elapsed since the edge that launched the current conversion.
  always_comb begin
    lat_launch = ((state_q == IDLE) && bus.start) || ((state_q == DONE) && bus.cont);
    if (lat_launch) begin
      lat_d = 1;
    end else if (state_q == DONE) begin
      lat_d = 0;
    end else if (lat_q != 0) begin
      lat_d = lat_q + 1;
    end else begin
      lat_d = lat_q;
    end
  end

  // Latency tracker register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= 0;
    end else begin
      lat_q <= lat_d;
    end
  end

  // done must land exactly on the nominal conversion latency.
  always @(posedge clk) begin
    if (rst_n && state_q == DONE) begin
      assert (lat_q == conv_cycles(WIDTH, SETTLE_CYCLES));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_adc_ctrl
//  Description : Self-checking bench for sar_adc_ctrl. Two instances: default
//                parameters and WIDTH=8 / SETTLE_CYCLES=2. The comparator is
//                modelled as (Vcode >= dac_code), updated after each edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sar_adc_ctrl;

  localparam int W0 = 3;
  localparam int S0 = 4;
  localparam int Y0 = 2;
  localparam int W1 = 8;
  localparam int S1 = 2;
  localparam int Y1 = 2;
  localparam int CONV0 = sar_adc_pkg::conv_cycles(W0, S0);
  localparam int CONV1 = sar_adc_pkg::conv_cycles(W1, S1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.WIDTH(W0)) bus0 ();
  sar_adc_ctrl_if #(.WIDTH(W1)) bus1 ();

  sar_adc_ctrl #(.WIDTH(W0), .SETTLE_CYCLES(S0), .SYNC_STAGES(Y0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sar_adc_ctrl #(.WIDTH(W1), .SETTLE_CYCLES(S1), .SYNC_STAGES(Y1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Analog input level presented to each instance's comparator.
  int vcode [2];

  // Comparator: responds to the code the DAC shows in the current cycle.
  always @(negedge clk) begin
    bus0.cmp_in <= (vcode[0] >= int'(bus0.dac_code));
    bus1.cmp_in <= (vcode[1] >= int'(bus1.dac_code));
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age = cycles since the launching edge (0 = idle); cvc = input level
  // captured at launch; last = most recently published result.
  int   age  [2];
  int   cvc  [2];
  int   last [2];
  logic st_v [2];
  logic ct_v [2];

  assign st_v[0] = bus0.start;
  assign st_v[1] = bus1.start;
  assign ct_v[0] = bus0.cont;
  assign ct_v[1] = bus1.cont;

  function automatic int conv_of(input int i);
    return (i == 0) ? CONV0 : CONV1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        age[i]  <= 0;
        cvc[i]  <= 0;
        last[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (age[i] == 0) begin
          if (st_v[i]) begin
            age[i] <= 1;
            cvc[i] <= vcode[i];
          end
        end else if (age[i] == conv_of(i)) begin
          last[i] <= cvc[i];
          if (ct_v[i]) begin
            age[i] <= 1;
            cvc[i] <= vcode[i];
          end else begin
            age[i] <= 0;
          end
        end else begin
          age[i] <= age[i] + 1;
        end
      end
    end
  end

  // Binary search view: during bit b the upper b bits already equal the
  // input's upper b bits and the trial bit is the next one down.
  function automatic void expect_at(input int w, input int s, input int vc,
                                    input int ag, input int lst,
                                    output int dac, output int busy,
                                    output int done, output int res);
    int conv = w * (s + 1) + 1;
    int b;
    int acc;
    dac = lst; busy = 0; done = 0; res = lst;
    if (ag > 0 && ag < conv) begin
      b    = (ag - 1) / (s + 1);
      acc  = (vc >> (w - b)) << (w - b);
      dac  = acc | (1 << (w - 1 - b));
      busy = 1;
    end else if (ag == conv) begin
      dac  = vc;
      done = 1;
      res  = vc;
    end
  endfunction

  task automatic cmp_dut(input string tag, input int w, input int s,
                         input int vc, input int ag, input int lst,
                         input int dac, input int busy, input int done,
                         input int res);
    int e_dac, e_busy, e_done, e_res;
    expect_at(w, s, vc, ag, lst, e_dac, e_busy, e_done, e_res);
    check({tag, ".dac_code"}, dac, e_dac);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".done"}, done, e_done);
    check({tag, ".result"}, res, e_res);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut("dut0", W0, S0, cvc[0], age[0], last[0], int'(bus0.dac_code),
              int'(bus0.busy), int'(bus0.done), int'(bus0.result));
      cmp_dut("dut1", W1, S1, cvc[1], age[1], last[1], int'(bus1.dac_code),
              int'(bus1.busy), int'(bus1.done), int'(bus1.result));
    end
  end

  // ---------------- directed stimulus ----------------
  // Called on a negedge: raises start for this cycle, then observes ncyc
  // cycles. start stays high for sampling edges 0..hold.
  task automatic run0(input int v, input int hold, input int ncyc,
                      output int first_done, output int last_done,
                      output int n_done, output int busy_n,
                      output int d1, output int d6, output int d11,
                      output int res_first);
    first_done = 0; last_done = 0; n_done = 0; busy_n = 0;
    d1 = -1; d6 = -1; d11 = -1; res_first = -1;
    vcode[0]   = v;
    bus0.start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus0.done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          res_first  = int'(bus0.result);
        end
        last_done = c;
      end
      if (bus0.busy) busy_n++;
      if (c == 1)  d1  = int'(bus0.dac_code);
      if (c == 6)  d6  = int'(bus0.dac_code);
      if (c == 11) d11 = int'(bus0.dac_code);
      bus0.start = (c <= hold);
    end
  endtask

  initial begin
    int fd, ld, nd, bn, d1, d6, d11, rf;
    int r1, r2, t1, t2, busy17;

    vcode[0] = 0; vcode[1] = 0;
    bus0.start = 1'b0; bus0.cont = 1'b0;
    bus1.start = 1'b0; bus1.cont = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.dac_code", int'(bus0.dac_code), 0);
    check("rst.busy",     int'(bus0.busy),     0);
    check("rst.done",     int'(bus0.done),     0);
    check("rst.result",   int'(bus0.result),   0);
    rst_n = 1'b1;

    // 1. Mid-scale input
    run0(5, 0, 20, fd, ld, nd, bn, d1, d6, d11, rf);
    check("mid.trial_msb", d1,  4);
    check("mid.trial_2",   d6,  6);
    check("mid.trial_3",   d11, 5);
    check("mid.done_cycle", fd, 16);
    check("mid.done_count", nd, 1);
    check("mid.busy_cycles", bn, 15);
    check("mid.result",     rf, 5);

    // 2. Extremes
    run0(0, 0, 20, fd, ld, nd, bn, d1, d6, d11, rf);
    check("zero.trial_msb", d1,  4);
    check("zero.trial_2",   d6,  2);
    check("zero.trial_3",   d11, 1);
    check("zero.result",    rf,  0);
    run0(7, 0, 20, fd, ld, nd, bn, d1, d6, d11, rf);
    check("full.trial_msb", d1,  4);
    check("full.trial_2",   d6,  6);
    check("full.trial_3",   d11, 7);
    check("full.result",    rf,  7);

    // 3. start held through busy and DONE is ignored
    run0(4, 16, 40, fd, ld, nd, bn, d1, d6, d11, rf);
    check("hold.done_count", nd, 1);
    check("hold.result",     rf, 4);
    // start still high on the first IDLE cycle launches a new conversion
    run0(1, 17, 40, fd, ld, nd, bn, d1, d6, d11, rf);
    check("rehold.done_count", nd, 2);
    check("rehold.second_done", ld, 33);
    check("rehold.busy_cycles", bn, 30);

    // 4. Continuous mode
    vcode[0] = 3; bus0.cont = 1'b1; bus0.start = 1'b1;
    r1 = -1; r2 = -1; t1 = 0; t2 = 0; nd = 0; busy17 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (bus0.done) begin
        nd++;
        if (t1 == 0) begin
          t1 = c; r1 = int'(bus0.result);
          vcode[0] = 6;
        end else begin
          t2 = c; r2 = int'(bus0.result);
        end
      end
      if (c == 17) begin
        busy17    = int'(bus0.busy);
        bus0.cont = 1'b0;
      end
    end
    check("cont.result_1", r1, 3);
    check("cont.result_2", r2, 6);
    check("cont.done_1",   t1, 16);
    check("cont.gap",      t2 - t1, 16);
    check("cont.no_idle",  busy17, 1);
    check("cont.done_count", nd, 2);

    // 5. Reset mid-conversion
    vcode[0] = 1; bus0.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst.dac_code", int'(bus0.dac_code), 0);
    check("midrst.busy",     int'(bus0.busy),     0);
    check("midrst.done",     int'(bus0.done),     0);
    check("midrst.result",   int'(bus0.result),   0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus0.done) nd++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus0.done) nd++;
    end
    check("midrst.no_done", nd, 0);
    run0(2, 0, 20, fd, ld, nd, bn, d1, d6, d11, rf);
    check("postrst.result",     rf, 2);
    check("postrst.done_cycle", fd, 16);

    // 6. WIDTH=8, SETTLE_CYCLES=2
    vcode[1] = 'hA5; bus1.start = 1'b1;
    fd = 0; rf = -1; d1 = -1; nd = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (c == 1) d1 = int'(bus1.dac_code);
      if (bus1.done) begin
        nd++;
        if (fd == 0) begin
          fd = c; rf = int'(bus1.result);
        end
      end
    end
    check("w8.trial_msb",  d1, 128);
    check("w8.done_cycle", fd, 25);
    check("w8.result",     rf, 'hA5);
    check("w8.done_count", nd, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
